// File: rtl/cdb_broadcast_arb_if.sv
// CDB producer interface: FU completion inputs, per-FU ready back-pressure,
// and the CDB_W broadcast lanes (tag, value, source FU index).
interface cdb_broadcast_arb_if #(
  parameter int N_FU  = 8,
  parameter int CDB_W = 3,
  parameter int PR_W  = 6,
  parameter int XLEN  = 32
);
  localparam int IDX_W = $clog2(N_FU);

  logic [N_FU-1:0]        fu_done;
  logic [N_FU*PR_W-1:0]   fu_dest_pr;
  logic [N_FU*XLEN-1:0]   fu_value;
  logic [N_FU-1:0]        fu_ready;
  logic [CDB_W-1:0]       cdb_valid;
  logic [CDB_W*PR_W-1:0]  cdb_tag;
  logic [CDB_W*XLEN-1:0]  cdb_value;
  logic [CDB_W*IDX_W-1:0] cdb_fu_idx;

  // Arbiter side: consumes completions, drives ready and the broadcast lanes.
  modport master (
    input  fu_done, fu_dest_pr, fu_value,
    output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_fu_idx
  );

  // FU / consumer side.
  modport slave (
    output fu_done, fu_dest_pr, fu_value,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_fu_idx
  );
endinterface

// File: rtl/cdb_broadcast_arb.sv
// CDB broadcast arbiter: one result slot per functional unit, up to CDB_W
// slots broadcast per cycle, chosen round-robin starting at rr_ptr.
// Lane 0 carries the granted slot closest to rr_ptr.
module cdb_broadcast_arb #(
  parameter int N_FU  = 8,
  parameter int CDB_W = 3,
  parameter int PR_W  = 6,
  parameter int XLEN  = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 squash,
  cdb_broadcast_arb_if.master  bus
);
  localparam int IDX_W  = $clog2(N_FU);
  localparam int LANE_W = (CDB_W > 1) ? $clog2(CDB_W) : 1;

  logic [N_FU-1:0]  slot_valid;
  logic [PR_W-1:0]  slot_tag   [N_FU];
  logic [XLEN-1:0]  slot_value [N_FU];
  logic [IDX_W-1:0] rr_ptr;

  logic [N_FU-1:0]  grant;
  logic [N_FU-1:0]  store;
  logic [IDX_W-1:0] rr_next;
  logic             any_grant;
  logic [CDB_W-1:0] lane_vld;
  logic [IDX_W-1:0] lane_idx [CDB_W];
  logic [LANE_W-1:0] lane_cnt;
  logic             lanes_full;
  logic [IDX_W-1:0] scan_idx;

  // Round-robin scan from rr_ptr: the first CDB_W held slots win, in lane order.
  always_comb begin
    grant      = '0;
    lane_vld   = '0;
    rr_next    = rr_ptr;
    any_grant  = 1'b0;
    lane_cnt   = '0;
    lanes_full = 1'b0;
    scan_idx   = '0;
    for (int k = 0; k < CDB_W; k++) lane_idx[k] = '0;
    for (int j = 0; j < N_FU; j++) begin
      scan_idx = IDX_W'((int'(rr_ptr) + j) % N_FU);
      if (slot_valid[scan_idx] && !lanes_full) begin
        grant[scan_idx]    = 1'b1;
        lane_vld[lane_cnt] = 1'b1;
        lane_idx[lane_cnt] = scan_idx;
        any_grant          = 1'b1;
        rr_next            = IDX_W'((int'(scan_idx) + 1) % N_FU);
        if (lane_cnt == LANE_W'(CDB_W - 1)) lanes_full = 1'b1;
        else lane_cnt = lane_cnt + 1'b1;
      end
    end
  end

  // A slot being broadcast this cycle can take a new result in the same cycle.
  assign bus.fu_ready = ~slot_valid | grant;

  // Accepted completions with a real destination are held; tag 0 is consumed silently.
  always_comb begin
    store = '0;
    for (int i = 0; i < N_FU; i++)
      store[i] = bus.fu_done[i] && bus.fu_ready[i] &&
                 (bus.fu_dest_pr[i*PR_W +: PR_W] != '0);
  end

  // Slot occupancy and round-robin pointer; squash clears both and drops new completions.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
    end else if (squash) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (store[i])      slot_valid[i] <= 1'b1;
        else if (grant[i]) slot_valid[i] <= 1'b0;
      end
      if (any_grant) rr_ptr <= rr_next;
    end
  end

  // Slot payload; only meaningful while slot_valid is set, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_FU; i++) begin
      if (store[i]) begin
        slot_tag[i]   <= bus.fu_dest_pr[i*PR_W +: PR_W];
        slot_value[i] <= bus.fu_value[i*XLEN +: XLEN];
      end
    end
  end

  // Lane outputs: granted slot contents, forced to zero on idle lanes.
  always_comb begin
    bus.cdb_valid  = lane_vld;
    bus.cdb_tag    = '0;
    bus.cdb_value  = '0;
    bus.cdb_fu_idx = '0;
    for (int k = 0; k < CDB_W; k++) begin
      if (lane_vld[k]) begin
        bus.cdb_tag[k*PR_W +: PR_W]     = slot_tag[lane_idx[k]];
        bus.cdb_value[k*XLEN +: XLEN]   = slot_value[lane_idx[k]];
        bus.cdb_fu_idx[k*IDX_W +: IDX_W] = lane_idx[k];
      end
    end
  end

  // Issue logic must never complete into an FU whose previous result is still unsent.
  a_no_overrun: assert property (@(posedge clock) disable iff (!reset_n)
    (bus.fu_done & ~bus.fu_ready) == '0);

endmodule

// File: tb/tb_cdb_broadcast_arb.sv
// Directed bench for cdb_broadcast_arb with a per-FU scoreboard of sent results.
module tb_cdb_broadcast_arb;
  localparam int N_FU  = 8;
  localparam int CDB_W = 3;
  localparam int PR_W  = 6;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [PR_W-1:0] tag;
    logic [XLEN-1:0] val;
  } res_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic squash  = 1'b0;

  cdb_broadcast_arb_if #(.N_FU(N_FU), .CDB_W(CDB_W), .PR_W(PR_W), .XLEN(XLEN)) bus ();

  cdb_broadcast_arb #(.N_FU(N_FU), .CDB_W(CDB_W), .PR_W(PR_W), .XLEN(XLEN)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .squash  (squash),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  res_t sb [N_FU][$];
  int   errors = 0;
  int   checks = 0;
  int   tcount = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic clr_in();
    bus.fu_done    = '0;
    bus.fu_dest_pr = '0;
    bus.fu_value   = '0;
    squash         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clr_in();
  endtask

  task automatic fu_complete(input int i, input logic [PR_W-1:0] tag,
                             input logic [XLEN-1:0] val, input bit expect_bcast);
    res_t r;
    bus.fu_done[i]                  = 1'b1;
    bus.fu_dest_pr[i*PR_W +: PR_W]  = tag;
    bus.fu_value[i*XLEN +: XLEN]    = val;
    if (expect_bcast && tag != '0) begin
      r.tag = tag;
      r.val = val;
      sb[i].push_back(r);
    end
  endtask

  function automatic logic [PR_W-1:0] next_tag();
    next_tag = PR_W'(1 + (tcount % 63));
    tcount++;
  endfunction

  task automatic check_cycle(input string name, input logic [N_FU-1:0] rdy,
                             input logic [CDB_W-1:0] vld, input int i0, input int i1, input int i2);
    int   exp_idx [CDB_W];
    res_t r;
    exp_idx[0] = i0;
    exp_idx[1] = i1;
    exp_idx[2] = i2;
    chk({name, "_ready"}, 64'(bus.fu_ready), 64'(rdy));
    chk({name, "_valid"}, 64'(bus.cdb_valid), 64'(vld));
    for (int k = 0; k < CDB_W; k++) begin
      if (vld[k]) begin
        chk($sformatf("%s_l%0d_idx", name, k), 64'(bus.cdb_fu_idx[k*3 +: 3]), 64'(exp_idx[k]));
        chk($sformatf("%s_l%0d_sb_has", name, k), 64'(sb[exp_idx[k]].size() != 0), 64'(1));
        if (sb[exp_idx[k]].size() != 0) begin
          r = sb[exp_idx[k]].pop_front();
          chk($sformatf("%s_l%0d_tag", name, k), 64'(bus.cdb_tag[k*PR_W +: PR_W]), 64'(r.tag));
          chk($sformatf("%s_l%0d_val", name, k), 64'(bus.cdb_value[k*XLEN +: XLEN]), 64'(r.val));
        end
      end else begin
        chk($sformatf("%s_l%0d_tag0", name, k), 64'(bus.cdb_tag[k*PR_W +: PR_W]), 64'(0));
        chk($sformatf("%s_l%0d_val0", name, k), 64'(bus.cdb_value[k*XLEN +: XLEN]), 64'(0));
        chk($sformatf("%s_l%0d_idx0", name, k), 64'(bus.cdb_fu_idx[k*3 +: 3]), 64'(0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [3:0] f_rdy [4];
    int         f_idx [4][3];
    int         p;
    int         left;
    f_rdy = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    f_idx = '{'{0, 1, 2}, '{3, 0, 1}, '{2, 3, 0}, '{1, 2, 3}};

    // Reset held, then released; idle stays idle.
    clr_in();
    reset_n = 1'b0;
    tick();
    tick();
    check_cycle("reset", 8'hFF, 3'b000, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_cycle("idle", 8'hFF, 3'b000, 0, 0, 0);

    // Single completion: broadcast next cycle on lane 0, then quiet.
    fu_complete(0, 6'd5, 32'h0000_DEAD, 1'b1);
    tick();
    check_cycle("single", 8'hFF, 3'b001, 0, 0, 0);
    tick();
    check_cycle("single_after", 8'hFF, 3'b000, 0, 0, 0);

    // Bring rr_ptr back to 0 before the overload case.
    squash = 1'b1;
    tick();
    check_cycle("sq_idle", 8'hFF, 3'b000, 0, 0, 0);

    // Overload: all eight FUs at once, tags 1..8.
    for (int i = 0; i < N_FU; i++) fu_complete(i, PR_W'(i + 1), $urandom, 1'b1);
    tick();
    check_cycle("ovl1", 8'b0000_0111, 3'b111, 0, 1, 2);
    tick();
    check_cycle("ovl2", 8'b0011_1111, 3'b111, 3, 4, 5);
    tick();
    check_cycle("ovl3", 8'hFF, 3'b011, 6, 7, 0);
    tick();
    check_cycle("ovl4", 8'hFF, 3'b000, 0, 0, 0);

    // Fairness: FU0..3 complete whenever ready; grant pattern repeats every 4 cycles.
    for (int i = 0; i < 4; i++) fu_complete(i, next_tag(), $urandom, 1'b1);
    tick();
    for (int c = 0; c < 8; c++) begin
      p = c % 4;
      check_cycle($sformatf("rr%0d", c), {4'hF, f_rdy[p]}, 3'b111,
                  f_idx[p][0], f_idx[p][1], f_idx[p][2]);
      if (c < 7)
        for (int i = 0; i < 4; i++)
          if (f_rdy[p][i]) fu_complete(i, next_tag(), $urandom, 1'b1);
      tick();
    end
    check_cycle("rr_drain", 8'hFF, 3'b001, 0, 0, 0);
    tick();
    check_cycle("rr_idle", 8'hFF, 3'b000, 0, 0, 0);

    // Destination tag 0: accepted, never broadcast (rr_ptr is 1 here).
    fu_complete(7, 6'd0, 32'h1234_5678, 1'b1);
    tick();
    check_cycle("nodest", 8'hFF, 3'b000, 0, 0, 0);

    // Five slots held, squash in that same cycle; a completion in the squash cycle is dropped.
    for (int i = 0; i < 5; i++) fu_complete(i, next_tag(), $urandom, 1'b1);
    tick();
    check_cycle("presq", 8'b1110_1110, 3'b111, 1, 2, 3);
    squash = 1'b1;
    fu_complete(5, 6'd9, 32'hBAD0_0005, 1'b0);
    tick();
    sb[0].delete();
    sb[4].delete();
    check_cycle("postsq", 8'hFF, 3'b000, 0, 0, 0);

    // rr_ptr is 0 after squash: FU0 must take lane 0 ahead of FU7.
    fu_complete(7, 6'd12, 32'hC0DE_0007, 1'b1);
    fu_complete(0, 6'd11, 32'hC0DE_0000, 1'b1);
    tick();
    check_cycle("rr_zero", 8'hFF, 3'b011, 0, 7, 0);

    // Asynchronous reset in mid-stream: outputs return to reset values at once.
    for (int i = 0; i < 5; i++) fu_complete(i, next_tag(), $urandom, 1'b1);
    tick();
    check_cycle("premid", 8'b1110_0111, 3'b111, 0, 1, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check_cycle("rst_mid", 8'hFF, 3'b000, 0, 0, 0);
    for (int i = 0; i < N_FU; i++) sb[i].delete();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_cycle("post_rst", 8'hFF, 3'b000, 0, 0, 0);

    // Every expected broadcast has been seen.
    left = 0;
    for (int i = 0; i < N_FU; i++) left += sb[i].size();
    chk("sb_empty", 64'(left), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
